// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: interval-timer register map, control bits, command ops and master FSM states
package timer_regs_pkg;
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;
  typedef enum logic [1:0] {
    OP_START    = 2'd0,
    OP_STOP     = 2'd1,
    OP_SNAPSHOT = 2'd2,
    OP_CLEAR    = 2'd3
  } cmd_op_e;
  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_ST,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_STOP,
    S_SN_WR,
    S_SN_RL,
    S_SN_RH,
    S_SN_CAP
  } state_e;
endpackage

// File: rtl/timer_avalon_master.sv
// timer_avalon_master: drives the 16-bit interval-timer slave from a command port and services its irq
module timer_avalon_master
  import timer_regs_pkg::*;
#(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              cmd_irq_en,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              timer_irq,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy
);
  state_e      state, next;
  cmd_op_e     op;
  logic        accept;
  logic [15:0] period_hi;
  logic        cont_q, irq_en_q;
  logic [15:0] snap_lo;
  logic [2:0]  addr_d;
  logic        cs_d, wn_d;
  logic [15:0] wd_d;
  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state == S_IDLE) && !timer_irq;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = state != S_IDLE;
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   next = timer_irq ? S_CLR_ST :
                       !cmd_valid ? S_IDLE :
                       op == OP_START ? S_WR_PL :
                       op == OP_STOP ? S_STOP :
                       op == OP_SNAPSHOT ? S_SN_WR : S_IDLE;
      S_WR_PL:  next = S_WR_PH;
      S_WR_PH:  next = S_WR_CTL;
      S_SN_WR:  next = S_SN_RL;
      S_SN_RL:  next = S_SN_RH;
      S_SN_RH:  next = S_SN_CAP;
      default:  next = S_IDLE;
    endcase
  end
  // Bus signals are precomputed for the state being entered so each state owns exactly one registered bus cycle
  always_comb begin
    cs_d   = 1'b1;
    wn_d   = 1'b0;
    addr_d = 3'd0;
    wd_d   = 16'h0000;
    unique case (next)
      S_CLR_ST: addr_d = ADDR_STATUS;
      S_WR_PL:  begin addr_d = ADDR_PERIODL; wd_d = cmd_period[15:0]; end
      S_WR_PH:  begin addr_d = ADDR_PERIODH; wd_d = period_hi; end
      S_WR_CTL: begin addr_d = ADDR_CONTROL; wd_d = {12'b0, 1'b0, 1'b1, cont_q, irq_en_q}; end
      S_STOP:   begin addr_d = ADDR_CONTROL; wd_d = 16'(1 << STOP); end
      S_SN_WR:  addr_d = ADDR_SNAPL;
      S_SN_RL:  begin addr_d = ADDR_SNAPL; wn_d = 1'b1; end
      S_SN_RH:  begin addr_d = ADDR_SNAPH; wn_d = 1'b1; end
      default:  begin cs_d = 1'b0; wn_d = 1'b1; end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 3'd0;
      avm_writedata  <= 16'h0000;
    end else begin
      state          <= next;
      avm_chipselect <= cs_d;
      avm_write_n    <= wn_d;
      avm_address    <= addr_d;
      avm_writedata  <= wd_d;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_hi <= 16'h0000;
      cont_q    <= 1'b0;
      irq_en_q  <= 1'b0;
    end else if (accept) begin
      period_hi <= cmd_period[31:16];
      cont_q    <= cmd_continuous;
      irq_en_q  <= cmd_irq_en;
    end
  end
  // A clear request takes precedence over a concurrent timeout increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick       <= next == S_CLR_ST;
      tick_count <= (accept && op == OP_CLEAR) ? '0 :
                    (next == S_CLR_ST) ? tick_count + 1'b1 : tick_count;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo    <= 16'h0000;
      snap_value <= 32'h0;
      snap_valid <= 1'b0;
    end else begin
      snap_lo    <= (state == S_SN_RH) ? avm_readdata : snap_lo;
      snap_value <= (state == S_SN_CAP) ? {avm_readdata, snap_lo} : snap_value;
      snap_valid <= state == S_SN_CAP;
    end
  end
endmodule
